// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the instruction fetch stage.
//  - fetch_state_e : fetch FSM state encoding (3 bits)
//  - INSTR_W       : instruction word width
//  - NOP_INSTR     : idle/reset instruction value used by decode
package instruction_fetch_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        HOLD = 3'd3,
        ADV  = 3'd4,
        ERR  = 3'd5
    } fetch_state_e;

    localparam int INSTR_W = 32;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

endpackage : instruction_fetch_pkg

// File: rtl/instruction_fetch_timeout_counter.sv
// Bus-response watchdog for the fetch FSM.
//  i_clk   : clock
//  i_rst_n : asynchronous active-low reset
//  clear   : restart the count (fetch request issued)
//  enable  : count one cycle spent waiting for data
//  expired : the current cycle is the last one allowed (count == TIMEOUT_CYCLES-1)
// The count saturates at TIMEOUT_CYCLES instead of wrapping, so a stray
// enable after expiry can never make the watchdog look fresh again.
module instruction_fetch_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] count_r;

    // Wait-cycle counter with clear priority and saturation
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count_r <= '0;
        end else if (clear) begin
            count_r <= '0;
        end else if (enable && (count_r != CNT_W'(TIMEOUT_CYCLES))) begin
            count_r <= count_r + CNT_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign expired = (count_r == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule : instruction_fetch_timeout_counter

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: reads the PC, fetches one word over the
// instruction bus, presents it to decode with a valid/ack handshake, then
// pulses o_load_PC so the program counter block can advance.
// Ports:
//  i_clk, i_rst_n          : clock, asynchronous active-low reset
//  i_PC                    : current program counter (sampled only in REQ)
//  o_load_PC               : 1-cycle pulse, PC may update at this edge
//  o_bus_addr / o_bus_rd   : fetch address (held) and 1-cycle read strobe
//  i_bus_data / i_bus_DV   : read data and its 1-cycle valid
//  o_instr / o_instr_DV    : fetched word and valid, held until i_instr_ack
//  i_instr_ack             : decode consumed o_instr
//  o_bus_err               : sticky fetch error, cleared only by reset
// Optional build macro FETCH_ALIGN_CHECK_EN: a PC with nonzero bits [1:0]
// skips the bus read and goes straight to the error state.
// All outputs come straight from registers.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = INSTR_W,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [ADDR_W-1:0] i_PC,
    output logic              o_load_PC,
    output logic [ADDR_W-1:0] o_bus_addr,
    output logic              o_bus_rd,
    input  logic [DATA_W-1:0] i_bus_data,
    input  logic              i_bus_DV,
    output logic [DATA_W-1:0] o_instr,
    output logic              o_instr_DV,
    input  logic              i_instr_ack,
    output logic              o_bus_err
);

    fetch_state_e      state_r,      state_nxt_s;
    logic [ADDR_W-1:0] bus_addr_r,   bus_addr_nxt_s;
    logic              bus_rd_r,     bus_rd_nxt_s;
    logic [DATA_W-1:0] instr_r,      instr_nxt_s;
    logic              instr_dv_r,   instr_dv_nxt_s;
    logic              load_pc_r,    load_pc_nxt_s;
    logic              bus_err_r,    bus_err_nxt_s;
    logic              cnt_clear_s;
    logic              cnt_en_s;
    logic              cnt_expired_s;

    instruction_fetch_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .clear   (cnt_clear_s),
        .enable  (cnt_en_s),
        .expired (cnt_expired_s)
    );

    // Next-state and next-output decode; strobes default low every cycle
    always_comb begin
        state_nxt_s    = state_r;
        bus_addr_nxt_s = bus_addr_r;
        bus_rd_nxt_s   = 1'b0;
        instr_nxt_s    = instr_r;
        instr_dv_nxt_s = instr_dv_r;
        load_pc_nxt_s  = 1'b0;
        bus_err_nxt_s  = bus_err_r;
        cnt_clear_s    = 1'b0;
        cnt_en_s       = 1'b0;

        case (state_r)
            IDLE: begin
                state_nxt_s = REQ;
            end
            REQ: begin
                cnt_clear_s    = 1'b1;
                bus_addr_nxt_s = i_PC;
`ifdef FETCH_ALIGN_CHECK_EN
                if (i_PC[1:0] != 2'b00) begin
                    bus_err_nxt_s = 1'b1;
                    state_nxt_s   = ERR;
                end else begin
                    bus_rd_nxt_s = 1'b1;
                    state_nxt_s  = WAIT;
                end
`else
                bus_rd_nxt_s = 1'b1;
                state_nxt_s  = WAIT;
`endif
            end
            WAIT: begin
                // Data arriving in the final allowed cycle beats the timeout
                if (i_bus_DV) begin
                    instr_nxt_s    = i_bus_data;
                    instr_dv_nxt_s = 1'b1;
                    state_nxt_s    = HOLD;
                end else begin
                    cnt_en_s = 1'b1;
                    if (cnt_expired_s) begin
                        bus_err_nxt_s = 1'b1;
                        state_nxt_s   = ERR;
                    end else begin
                        state_nxt_s = WAIT;
                    end
                end
            end
            HOLD: begin
                if (i_instr_ack) begin
                    instr_dv_nxt_s = 1'b0;
                    load_pc_nxt_s  = 1'b1;
                    state_nxt_s    = ADV;
                end else begin
                    state_nxt_s = HOLD;
                end
            end
            ADV: begin
                // PC updates at the end of this cycle; REQ then sees the new value
                state_nxt_s = REQ;
            end
            ERR: begin
                bus_err_nxt_s  = 1'b1;
                instr_dv_nxt_s = 1'b0;
                state_nxt_s    = ERR;
            end
            default: begin
                // Unreachable encoding: park safely and flag it
                bus_err_nxt_s  = 1'b1;
                instr_dv_nxt_s = 1'b0;
                state_nxt_s    = ERR;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r    <= IDLE;
            bus_addr_r <= '0;
            bus_rd_r   <= 1'b0;
            instr_r    <= '0;
            instr_dv_r <= 1'b0;
            load_pc_r  <= 1'b0;
            bus_err_r  <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            bus_addr_r <= bus_addr_nxt_s;
            bus_rd_r   <= bus_rd_nxt_s;
            instr_r    <= instr_nxt_s;
            instr_dv_r <= instr_dv_nxt_s;
            load_pc_r  <= load_pc_nxt_s;
            bus_err_r  <= bus_err_nxt_s;
        end
    end

    assign o_bus_addr = bus_addr_r;
    assign o_bus_rd   = bus_rd_r;
    assign o_instr    = instr_r;
    assign o_instr_DV = instr_dv_r;
    assign o_load_PC  = load_pc_r;
    assign o_bus_err  = bus_err_r;

endmodule : instruction_fetch

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch. Inputs are driven and outputs are
// sampled on the falling clock edge; each vector row holds the inputs for
// the next rising edge and the outputs expected right after it.
module tb_instruction_fetch;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int TMO    = 8;

    localparam logic [31:0] I0  = 32'h0050_0093;
    localparam logic [31:0] I1  = 32'hAAAA_0001;
    localparam logic [31:0] I2  = 32'h00A0_0113;
    localparam logic [31:0] I3  = 32'h1234_5678;
    localparam logic [31:0] JNK = 32'hFFFF_EEEE;
    localparam logic [31:0] JPC = 32'hDEAD_BEE0;

    logic              i_clk = 1'b0;
    logic              i_rst_n = 1'b0;
    logic [ADDR_W-1:0] i_PC = '0;
    logic              o_load_PC;
    logic [ADDR_W-1:0] o_bus_addr;
    logic              o_bus_rd;
    logic [DATA_W-1:0] i_bus_data = '0;
    logic              i_bus_DV = 1'b0;
    logic [DATA_W-1:0] o_instr;
    logic              o_instr_DV;
    logic              i_instr_ack = 1'b0;
    logic              o_bus_err;

    always #5 i_clk = ~i_clk;

    instruction_fetch #(
        .ADDR_W         (ADDR_W),
        .DATA_W         (DATA_W),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_PC        (i_PC),
        .o_load_PC   (o_load_PC),
        .o_bus_addr  (o_bus_addr),
        .o_bus_rd    (o_bus_rd),
        .i_bus_data  (i_bus_data),
        .i_bus_DV    (i_bus_DV),
        .o_instr     (o_instr),
        .o_instr_DV  (o_instr_DV),
        .i_instr_ack (i_instr_ack),
        .o_bus_err   (o_bus_err)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] pc;
        logic        bdv;
        logic [31:0] bdata;
        logic        ack;
        logic        rd;
        logic [31:0] addr;
        logic        dv;
        logic [31:0] instr;
        logic        ld;
        logic        err;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic rd, input logic [31:0] addr,
                           input logic dv, input logic [31:0] instr, input logic ld,
                           input logic err);
        chk({tag, " rd"},    {31'd0, o_bus_rd},   {31'd0, rd});
        chk({tag, " addr"},  o_bus_addr,          addr);
        chk({tag, " dv"},    {31'd0, o_instr_DV}, {31'd0, dv});
        chk({tag, " instr"}, o_instr,             instr);
        chk({tag, " load"},  {31'd0, o_load_PC},  {31'd0, ld});
        chk({tag, " err"},   {31'd0, o_bus_err},  {31'd0, err});
    endtask

    task automatic add(input logic [31:0] pc, input logic bdv, input logic [31:0] bdata,
                       input logic ack, input logic rd, input logic [31:0] addr,
                       input logic dv, input logic [31:0] instr, input logic ld,
                       input logic err);
        vec_t v;
        v.pc = pc; v.bdv = bdv; v.bdata = bdata; v.ack = ack;
        v.rd = rd; v.addr = addr; v.dv = dv; v.instr = instr; v.ld = ld; v.err = err;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic [31:0] pc, input logic bdv, input logic [31:0] bdata,
                         input logic ack);
        i_PC        = pc;
        i_bus_DV    = bdv;
        i_bus_data  = bdata;
        i_instr_ack = ack;
    endtask

    task automatic step();
        @(negedge i_clk);
    endtask

    // Called at a falling edge: pulse reset for one cycle, release with pc
    task automatic do_reset(input logic [31:0] pc);
        i_rst_n = 1'b0;
        drive(32'd0, 1'b0, 32'd0, 1'b0);
        step();
        i_rst_n = 1'b1;
        i_PC    = pc;
    endtask

    initial begin : main
        int cycles;

        // ---- reset state ----
        step();
        step();
        chk_out("reset", 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);

        // ---- vector table: tests 1-3 plus ignored-input cases ----
        //   pc      dv    data  ack  | rd    addr      dv    instr ld    err
        add(32'h0,   1'b0, 32'h0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0, 1'b0, 1'b0); // IDLE->REQ
        add(32'h0,   1'b0, 32'h0, 1'b1, 1'b1, 32'h0,   1'b0, 32'h0, 1'b0, 1'b0); // REQ->WAIT, ack ignored
        add(32'h0,   1'b1, I0,    1'b0, 1'b0, 32'h0,   1'b1, I0,    1'b0, 1'b0); // data -> HOLD
        add(32'h0,   1'b0, 32'h0, 1'b1, 1'b0, 32'h0,   1'b0, I0,    1'b1, 1'b0); // ack -> ADV
        add(32'h4,   1'b0, 32'h0, 1'b0, 1'b0, 32'h0,   1'b0, I0,    1'b0, 1'b0); // ADV->REQ
        add(32'h4,   1'b0, 32'h0, 1'b0, 1'b1, 32'h4,   1'b0, I0,    1'b0, 1'b0); // read @4
        add(32'h4,   1'b1, I1,    1'b0, 1'b0, 32'h4,   1'b1, I1,    1'b0, 1'b0); // HOLD
        // decode withholds ack for 10 cycles; late DV and PC changes ignored
        add(JPC,     1'b1, JNK,   1'b0, 1'b0, 32'h4,   1'b1, I1,    1'b0, 1'b0);
        for (int k = 0; k < 9; k++)
            add(JPC, 1'b0, 32'h0, 1'b0, 1'b0, 32'h4,   1'b1, I1,    1'b0, 1'b0);
        add(32'h8,   1'b0, 32'h0, 1'b1, 1'b0, 32'h4,   1'b0, I1,    1'b1, 1'b0); // ADV
        add(32'h8,   1'b0, 32'h0, 1'b0, 1'b0, 32'h4,   1'b0, I1,    1'b0, 1'b0); // REQ
        add(32'h8,   1'b0, 32'h0, 1'b0, 1'b1, 32'h8,   1'b0, I1,    1'b0, 1'b0); // read @8
        add(32'h8,   1'b0, 32'h0, 1'b0, 1'b0, 32'h8,   1'b0, I1,    1'b0, 1'b0); // bus slow
        add(32'h8,   1'b1, I2,    1'b0, 1'b0, 32'h8,   1'b1, I2,    1'b0, 1'b0); // HOLD
        add(32'h100, 1'b0, 32'h0, 1'b1, 1'b0, 32'h8,   1'b0, I2,    1'b1, 1'b0); // ADV
        add(32'h100, 1'b0, 32'h0, 1'b0, 1'b0, 32'h8,   1'b0, I2,    1'b0, 1'b0); // REQ
        add(32'h100, 1'b0, 32'h0, 1'b0, 1'b1, 32'h100, 1'b0, I2,    1'b0, 1'b0); // read @100
        add(32'h100, 1'b1, I3,    1'b1, 1'b0, 32'h100, 1'b1, I3,    1'b0, 1'b0); // ack in WAIT ignored
        add(32'h104, 1'b0, 32'h0, 1'b1, 1'b0, 32'h100, 1'b0, I3,    1'b1, 1'b0); // ack first HOLD cycle
        add(32'h104, 1'b0, 32'h0, 1'b0, 1'b0, 32'h100, 1'b0, I3,    1'b0, 1'b0); // REQ

        i_rst_n = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].pc, vecs[i].bdv, vecs[i].bdata, vecs[i].ack);
            step();
            chk_out($sformatf("vec%0d", i), vecs[i].rd, vecs[i].addr, vecs[i].dv,
                    vecs[i].instr, vecs[i].ld, vecs[i].err);
        end

        // ---- async reset mid-WAIT ----
        drive(32'h104, 1'b0, 32'h0, 1'b0);
        step();
        chk_out("pre_rst_wait", 1'b1, 32'h104, 1'b0, I3, 1'b0, 1'b0);
        i_rst_n = 1'b0;
        #1;
        chk_out("rst_wait", 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
        step();
        i_rst_n = 1'b1;
        i_PC    = 32'h200;
        step();
        chk_out("rst_wait_req", 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
        step();
        chk_out("rst_wait_rd", 1'b1, 32'h200, 1'b0, 32'd0, 1'b0, 1'b0);

        // ---- async reset mid-HOLD ----
        drive(32'h200, 1'b1, I0, 1'b0);
        step();
        chk_out("pre_rst_hold", 1'b0, 32'h200, 1'b1, I0, 1'b0, 1'b0);
        i_rst_n = 1'b0;
        #1;
        chk_out("rst_hold", 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
        drive(32'h300, 1'b0, 32'h0, 1'b0);
        step();
        i_rst_n = 1'b1;
        step();
        chk_out("rst_hold_req", 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
        step();
        chk_out("rst_hold_rd", 1'b1, 32'h300, 1'b0, 32'd0, 1'b0, 1'b0);

        // ---- timeout: bus never answers ----
        cycles = 0;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (o_bus_err) begin
                cycles = k;
                break;
            end
        end
        chk("timeout_cycles", cycles, 32'd8);
        for (int k = 0; k < 3; k++) begin
            drive(32'h300, 1'b1, I2, 1'b1);
            step();
            chk_out($sformatf("err_late%0d", k), 1'b0, 32'h300, 1'b0, 32'd0, 1'b0, 1'b1);
        end

        // ---- data in the final allowed WAIT cycle wins over timeout ----
        do_reset(32'h400);
        step();
        step();
        chk_out("edge_rd", 1'b1, 32'h400, 1'b0, 32'd0, 1'b0, 1'b0);
        for (int k = 0; k < TMO - 1; k++) step();
        chk_out("edge_wait", 1'b0, 32'h400, 1'b0, 32'd0, 1'b0, 1'b0);
        drive(32'h400, 1'b1, I3, 1'b0);
        step();
        chk_out("edge_dv", 1'b0, 32'h400, 1'b1, I3, 1'b0, 1'b0);
        drive(32'h400, 1'b0, 32'h0, 1'b0);
        step();
        chk_out("edge_hold", 1'b0, 32'h400, 1'b1, I3, 1'b0, 1'b0);

        // ---- misaligned PC ----
        do_reset(32'h6);
        step();
        step();
`ifdef FETCH_ALIGN_CHECK_EN
        chk_out("misalign", 1'b0, 32'h6, 1'b0, 32'd0, 1'b0, 1'b1);
        step();
        chk_out("misalign_err", 1'b0, 32'h6, 1'b0, 32'd0, 1'b0, 1'b1);
`else
        chk_out("misalign", 1'b1, 32'h6, 1'b0, 32'd0, 1'b0, 1'b0);
        step();
        chk_out("misalign_wait", 1'b0, 32'h6, 1'b0, 32'd0, 1'b0, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time limit so the run always terminates
    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule : tb_instruction_fetch
